vector_serializer: RTL and testbench



---
 rtl/vector_serializer_if.sv | 29 ++
 rtl/vector_serializer.sv | 125 ++++++++++++
 tb/tb_vector_serializer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_serializer_if.sv
// Handshake and serial-output bundle for vector_serializer.
//   iDato    : parallel word to send (WIDTH bits)
//   iValido  : iDato is valid
//   oListo   : serializer can accept a word this cycle
//   oSenal   : serial data out
//   oInicio  : first bit of a word is on oSenal
//   oFin     : last bit of a word is on oSenal
//   oOcupado : word being shifted or gap in progress
interface vector_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] iDato;
  logic             iValido;
  logic             oListo;
  logic             oSenal;
  logic             oInicio;
  logic             oFin;
  logic             oOcupado;

  modport master (
    output iDato, iValido,
    input  oListo, oSenal, oInicio, oFin, oOcupado
  );

  modport slave (
    input  iDato, iValido,
    output oListo, oSenal, oInicio, oFin, oOcupado
  );
endinterface

// File: rtl/vector_serializer.sv
// Parallel-to-serial stage: accepts a WIDTH-bit word on a valid/ready
// handshake and drives it one bit per clock on oSenal, with oInicio/oFin
// framing strobes and an optional idle gap after each word.
// Ports:
//   iclk   : clock, rising edge
//   ireset : synchronous reset, active-high
//   bus    : vector_serializer_if.slave (iDato, iValido in; oListo,
//            oSenal, oInicio, oFin, oOcupado out)
module vector_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input logic               iclk,
  input logic               ireset,
  vector_serializer_if.slave bus
);
  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT   = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST = 4'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bitcnt_q;
  logic [3:0]       gapcnt_q;
  logic             senal_q;
  logic             inicio_q;
  logic             fin_q;
  logic             ocupado_q;
  logic             listo;
  logic             take;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready depends only on state and counters, never on iValido.
  always_comb begin
    listo = 1'b0;
    case (state_q)
      S_IDLE:  listo = 1'b1;
      S_SHIFT: listo = (GAP == 0) && (bitcnt_q == LAST_BIT);
      S_GAP:   listo = (gapcnt_q == GAP_LAST);
      default: listo = 1'b0;
    endcase
  end

  assign take = bus.iValido && listo;

  // A transfer is only possible where listo is set, so handling it ahead
  // of the per-state logic covers the IDLE, last-bit and final-gap reloads.
  // The first bit is registered straight from iDato; shreg_q holds the rest.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
      senal_q   <= 1'b0;
      inicio_q  <= 1'b0;
      fin_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else if (take) begin
      state_q   <= S_SHIFT;
      shreg_q   <= advance(bus.iDato);
      senal_q   <= first_bit(bus.iDato);
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
      inicio_q  <= 1'b1;
      fin_q     <= 1'b0;
      ocupado_q <= 1'b1;
    end else begin
      case (state_q)
        S_SHIFT: begin
          inicio_q <= 1'b0;
          if (bitcnt_q != LAST_BIT) begin
            senal_q  <= first_bit(shreg_q);
            shreg_q  <= advance(shreg_q);
            bitcnt_q <= bitcnt_q + 1'b1;
            fin_q    <= (bitcnt_q == PENULT);
          end else if (GAP != 0) begin
            state_q  <= S_GAP;
            gapcnt_q <= 4'd1;
            senal_q  <= 1'b0;
            fin_q    <= 1'b0;
          end else begin
            state_q   <= S_IDLE;
            senal_q   <= 1'b0;
            fin_q     <= 1'b0;
            ocupado_q <= 1'b0;
          end
        end
        S_GAP: begin
          if (gapcnt_q != GAP_LAST) begin
            gapcnt_q <= gapcnt_q + 4'd1;
          end else begin
            state_q   <= S_IDLE;
            gapcnt_q  <= '0;
            ocupado_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          senal_q   <= 1'b0;
          inicio_q  <= 1'b0;
          fin_q     <= 1'b0;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oListo   = listo;
  assign bus.oSenal   = senal_q;
  assign bus.oInicio  = inicio_q;
  assign bus.oFin     = fin_q;
  assign bus.oOcupado = ocupado_q;
endmodule

// File: tb/tb_vector_serializer.sv
// Bench for vector_serializer: three instances (LSB-first/no gap,
// MSB-first/no gap, LSB-first/gap 2) checked every cycle against a
// queue-based reference of expected per-cycle outputs.
module tb_vector_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dato [3];
  logic       valid[3];
  logic       senal[3], inicio[3], fin[3], ocup[3], listo[3];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vector_serializer_if #(.WIDTH(8)) if0 ();
  vector_serializer_if #(.WIDTH(8)) if1 ();
  vector_serializer_if #(.WIDTH(8)) if2 ();

  vector_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0))
    dut0 (.iclk(clk), .ireset(rst), .bus(if0));
  vector_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0))
    dut1 (.iclk(clk), .ireset(rst), .bus(if1));
  vector_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2))
    dut2 (.iclk(clk), .ireset(rst), .bus(if2));

  assign if0.iDato = dato[0];  assign if0.iValido = valid[0];
  assign if1.iDato = dato[1];  assign if1.iValido = valid[1];
  assign if2.iDato = dato[2];  assign if2.iValido = valid[2];
  assign senal[0] = if0.oSenal; assign inicio[0] = if0.oInicio; assign fin[0] = if0.oFin;
  assign ocup[0] = if0.oOcupado; assign listo[0] = if0.oListo;
  assign senal[1] = if1.oSenal; assign inicio[1] = if1.oInicio; assign fin[1] = if1.oFin;
  assign ocup[1] = if1.oOcupado; assign listo[1] = if1.oListo;
  assign senal[2] = if2.oSenal; assign inicio[2] = if2.oInicio; assign fin[2] = if2.oFin;
  assign ocup[2] = if2.oOcupado; assign listo[2] = if2.oListo;

  // Reference: each accepted word schedules WIDTH bit-cycles followed by GAP
  // idle-but-busy cycles; the block is ready whenever nothing is scheduled.
  typedef struct packed {logic s; logic st; logic fi; logic oc;} ent_t;
  ent_t        mq[3][$];
  ent_t        e_ent[3];
  logic        e_listo[3];
  int unsigned cfg_msb[3] = '{0, 1, 0};
  int unsigned cfg_gap[3] = '{0, 0, 2};
  int unsigned idx;

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mq[d].delete();
        e_ent[d] = '0;
      end else begin
        if (valid[d] && mq[d].size() == 0) begin
          for (int i = 0; i < 8; i++) begin
            idx = (cfg_msb[d] != 0) ? 7 - i : i;
            mq[d].push_back('{s: dato[d][idx], st: (i == 0), fi: (i == 7), oc: 1'b1});
          end
          for (int g = 0; g < int'(cfg_gap[d]); g++)
            mq[d].push_back('{s: 1'b0, st: 1'b0, fi: 1'b0, oc: 1'b1});
        end
        e_ent[d] = (mq[d].size() > 0) ? mq[d].pop_front() : '0;
      end
      e_listo[d] = (mq[d].size() == 0);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin valid[d] = 1'b1; dato[d] = 8'($urandom); end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== 5'b00001) begin
        fails++;
        $display("FAIL reset dut%0d: got s/i/f/o/l=%b need 00001", d,
                 {senal[d], inicio[d], fin[d], ocup[d], listo[d]});
      end
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) valid[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb_first();
    logic [7:0] col = '0;
    int nst = 0, nfin = 0;
    valid[0] = 1'b1; dato[0] = 8'h0F;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid[0] = 1'b0;
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== {e_ent[d], e_listo[d]}) begin
          fails++;
          $display("FAIL lsb_first dut%0d cyc%0d: got s/i/f/o/l=%b need %b", d, c,
                   {senal[d], inicio[d], fin[d], ocup[d], listo[d]}, {e_ent[d], e_listo[d]});
        end
      end
      if (c <= 8) col[c-1] = senal[0];
      if (c == 1 && inicio[0] === 1'b1) nst++;
      if (c == 8 && fin[0] === 1'b1) nfin++;
      if (c == 9) begin
        tests++;
        if (senal[0] !== 1'b0) begin fails++; $display("FAIL lsb_after got %b need 0", senal[0]); end
      end
    end
    tests++;
    if (col !== 8'h0F || nst != 1 || nfin != 1) begin
      fails++;
      $display("FAIL lsb_word got %h st%0d fin%0d need 0f st1 fin1", col, nst, nfin);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] col = '0;
    valid[1] = 1'b1; dato[1] = 8'h0F;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid[1] = 1'b0;
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== {e_ent[d], e_listo[d]}) begin
          fails++;
          $display("FAIL msb_first dut%0d cyc%0d: got s/i/f/o/l=%b need %b", d, c,
                   {senal[d], inicio[d], fin[d], ocup[d], listo[d]}, {e_ent[d], e_listo[d]});
        end
      end
      if (c <= 8) col = {col[6:0], senal[1]};
    end
    tests++;
    if (col !== 8'h0F) begin fails++; $display("FAIL msb_word got %h need 0f", col); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] col = '0, stm = '0, fnm = '0;
    int idle = 0;
    valid[0] = 1'b1; dato[0] = 8'h01;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== {e_ent[d], e_listo[d]}) begin
          fails++;
          $display("FAIL back_to_back dut%0d cyc%0d: got s/i/f/o/l=%b need %b", d, c,
                   {senal[d], inicio[d], fin[d], ocup[d], listo[d]}, {e_ent[d], e_listo[d]});
        end
      end
      if (c <= 16) begin
        col[c-1] = senal[0]; stm[c-1] = inicio[0]; fnm[c-1] = fin[0];
        if (ocup[0] !== 1'b1) idle++;
      end
      dato[0] = 8'h80;
      valid[0] = (c < 9);
    end
    tests++;
    if (col !== 16'h8001 || stm !== 16'h0101 || fnm !== 16'h8080 || idle != 0) begin
      fails++;
      $display("FAIL b2b_stream got bits=%h st=%h fin=%h idle=%0d need 8001 0101 8080 0",
               col, stm, fnm, idle);
    end
  endtask

  task automatic test_gap();
    logic [7:0] w1 = 8'($urandom), w2 = 8'($urandom), col = '0;
    logic [2:0] lrec = '0;
    int fin1 = -1, st2 = -1;
    valid[2] = 1'b1; dato[2] = w1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== {e_ent[d], e_listo[d]}) begin
          fails++;
          $display("FAIL gap dut%0d cyc%0d: got s/i/f/o/l=%b need %b", d, c,
                   {senal[d], inicio[d], fin[d], ocup[d], listo[d]}, {e_ent[d], e_listo[d]});
        end
      end
      if (fin[2] === 1'b1 && fin1 < 0) fin1 = c;
      if (inicio[2] === 1'b1 && c > 1 && st2 < 0) st2 = c;
      if (c >= 8 && c <= 10) lrec[c-8] = listo[2];
      if (st2 > 0 && c >= st2 && c < st2 + 8) col[c-st2] = senal[2];
      dato[2] = w2;
      valid[2] = (c < 11);
    end
    tests++;
    if (fin1 != 8 || st2 - fin1 != 3 || lrec !== 3'b100 || col !== w2) begin
      fails++;
      $display("FAIL gap_timing got fin=%0d st2=%0d listo=%b w2=%h need 8 11 100 %h",
               fin1, st2, lrec, col, w2);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] col = '0, lm = '0;
    valid[0] = 1'b1; dato[0] = 8'hFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== {e_ent[d], e_listo[d]}) begin
          fails++;
          $display("FAIL ignore dut%0d cyc%0d: got s/i/f/o/l=%b need %b", d, c,
                   {senal[d], inicio[d], fin[d], ocup[d], listo[d]}, {e_ent[d], e_listo[d]});
        end
      end
      if (c <= 8) begin col[c-1] = senal[0]; lm[c-1] = listo[0]; end
      valid[0] = (c == 4);
      dato[0] = 8'h00;
    end
    tests++;
    if (col !== 8'hFF || lm !== 8'h80) begin
      fails++;
      $display("FAIL ignore_word got %h listo=%b need ff 10000000", col, lm);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] col = '0;
    int nfin = 0;
    valid[0] = 1'b1; dato[0] = 8'hAA;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      valid[0] = 1'b0;
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== {e_ent[d], e_listo[d]}) begin
          fails++;
          $display("FAIL reset_mid dut%0d cyc%0d: got s/i/f/o/l=%b need %b", d, c,
                   {senal[d], inicio[d], fin[d], ocup[d], listo[d]}, {e_ent[d], e_listo[d]});
        end
      end
      if (c <= 6 && fin[0] === 1'b1) nfin++;
      if (c >= 7 && c <= 14) col[c-7] = senal[0];
      if (c == 6) begin
        tests++;
        if ({senal[0], ocup[0], listo[0]} !== 3'b001) begin
          fails++;
          $display("FAIL reset_mid_state got s/o/l=%b need 001", {senal[0], ocup[0], listo[0]});
        end
      end
      rst = (c == 5);
      if (c == 6) begin valid[0] = 1'b1; dato[0] = 8'h01; end
    end
    tests++;
    if (nfin != 0 || col !== 8'h01) begin
      fails++;
      $display("FAIL reset_mid_after got fin=%0d word=%h need 0 01", nfin, col);
    end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({senal[d], inicio[d], fin[d], ocup[d], listo[d]} !== {e_ent[d], e_listo[d]}) begin
          fails++;
          $display("FAIL random dut%0d cyc%0d: got s/i/f/o/l=%b need %b", d, c,
                   {senal[d], inicio[d], fin[d], ocup[d], listo[d]}, {e_ent[d], e_listo[d]});
        end
        valid[d] = ($urandom_range(0, 3) != 0);
        dato[d]  = 8'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) valid[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin valid[d] = 1'b0; dato[d] = '0; end
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_gap();
    test_ignore_busy();
    test_reset_midword();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
